// File: rtl/o_ddr_serializer_if.sv
// Parallel word handshake into the DDR serializer: DATA carries all lanes, valid/ready per word.
interface o_ddr_serializer_if #(
   parameter int DW = 8
);
   logic [DW-1:0] DATA;
   logic          DATA_VALID;
   logic          DATA_READY;

   modport master (output DATA, output DATA_VALID, input DATA_READY);
   modport slave  (input DATA, input DATA_VALID, output DATA_READY);
endinterface

// File: rtl/o_ddr_serializer.sv
// Multi-lane DDR serializer: word accepted at posedge k shows bit0/bit1 in cycle k+1, then 2 bits/cycle.
// One-entry holding register; DATA_READY drops while it is full and the shifter cannot take it.
module o_ddr_serializer #(
   parameter int   WIDTH      = 8,
   parameter int   CHANNELS   = 1,
   parameter logic IDLE_VALUE = 1'b0
) (
   input  logic                C,
   input  logic                R,
   input  logic                E,
   o_ddr_serializer_if.slave   s_in,
   output logic [CHANNELS-1:0] Q,
   output logic                BUSY,
   output logic                UNDERFLOW
);

   localparam int HALF = WIDTH / 2;
   localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0]       LAST   = CW'(HALF - 1);
   localparam logic [CHANNELS-1:0] IDLE_V = {CHANNELS{IDLE_VALUE}};

   generate
      if ((WIDTH % 2) != 0 || WIDTH < 2 || WIDTH > 16) begin : g_bad_width
         $error("o_ddr_serializer: WIDTH must be even and within 2..16");
      end
      if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
         $error("o_ddr_serializer: CHANNELS must be within 1..16");
      end
   endgenerate

   logic [WIDTH-1:0]    r_hold  [CHANNELS];
   logic [WIDTH-1:0]    r_shift [CHANNELS];
   logic [WIDTH-1:0]    w_next  [CHANNELS];
   logic [CHANNELS-1:0] r_p0;
   logic [CHANNELS-1:0] r_p1;
   logic [CHANNELS-1:0] r_n1;
   logic [CW-1:0]       r_cnt;
   logic                r_hold_full;
   logic                r_busy;
   logic                r_underflow;
   logic                w_last;
   logic                w_load;
   logic                w_ready;
   logic                w_accept;

   assign w_last   = (r_cnt == LAST);
   assign w_load   = r_hold_full & (~r_busy | w_last);
   assign w_ready  = E & ~R & (~r_hold_full | w_load);
   assign w_accept = w_ready & s_in.DATA_VALID;

   assign s_in.DATA_READY = w_ready;
   assign BUSY            = r_busy;
   assign UNDERFLOW       = r_underflow & E;

   // Each slot consumes two bits, so the next pair always sits at [1:0] after the shift.
   always_comb begin
      for (int n = 0; n < CHANNELS; n++) begin
         w_next[n] = r_shift[n] >> 2;
      end
   end

   always_ff @(posedge C or posedge R) begin
      if (R) begin
         for (int n = 0; n < CHANNELS; n++) begin
            r_hold[n]  <= '0;
            r_shift[n] <= '0;
         end
         r_p0        <= IDLE_V;
         r_p1        <= IDLE_V;
         r_cnt       <= '0;
         r_hold_full <= 1'b0;
         r_busy      <= 1'b0;
         r_underflow <= 1'b0;
      end else if (!E) begin
         r_underflow <= 1'b0;
      end else begin
         r_underflow <= 1'b0;
         if (w_accept) begin
            for (int n = 0; n < CHANNELS; n++) begin
               r_hold[n] <= s_in.DATA[n*WIDTH +: WIDTH];
            end
         end
         if (w_accept) begin
            r_hold_full <= 1'b1;
         end else if (w_load) begin
            r_hold_full <= 1'b0;
         end
         if (w_load) begin
            for (int n = 0; n < CHANNELS; n++) begin
               r_shift[n] <= r_hold[n];
               r_p0[n]    <= r_hold[n][0];
               r_p1[n]    <= r_hold[n][1];
            end
            r_cnt  <= '0;
            r_busy <= 1'b1;
         end else if (r_busy && !w_last) begin
            for (int n = 0; n < CHANNELS; n++) begin
               r_shift[n] <= w_next[n];
               r_p0[n]    <= w_next[n][0];
               r_p1[n]    <= w_next[n][1];
            end
            r_cnt <= r_cnt + CW'(1);
         end else if (r_busy) begin
            // Last slot went out and nothing is waiting: the stream ran dry.
            r_p0        <= IDLE_V;
            r_p1        <= IDLE_V;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_underflow <= 1'b1;
         end
      end
   end

   always_ff @(negedge C or posedge R) begin
      if (R) begin
         r_n1 <= IDLE_V;
      end else if (E) begin
         r_n1 <= r_p1;
      end
   end

   always_comb begin
      Q = IDLE_V;
      if (!R) begin
         Q = C ? r_p0 : r_n1;
      end
   end

endmodule

// File: tb/tb_o_ddr_serializer.sv
// Bench for o_ddr_serializer: vector table, corner-case sequences, and a randomized run against a queue model.
`timescale 1ns/1ns
module tb_o_ddr_serializer;

   logic C = 1'b0;
   logic R = 1'b1;
   logic E = 1'b0;
   always #5 C = ~C;

   o_ddr_serializer_if #(.DW(8)) i8();
   o_ddr_serializer_if #(.DW(8)) i4();
   o_ddr_serializer_if #(.DW(2)) i2();

   logic [0:0] q8; logic b8, u8;
   logic [1:0] q4; logic b4, u4;
   logic [0:0] q2; logic b2, u2;

   o_ddr_serializer #(.WIDTH(8), .CHANNELS(1), .IDLE_VALUE(1'b0)) dut8 (
      .C(C), .R(R), .E(E), .s_in(i8.slave), .Q(q8), .BUSY(b8), .UNDERFLOW(u8));
   o_ddr_serializer #(.WIDTH(4), .CHANNELS(2), .IDLE_VALUE(1'b0)) dut4 (
      .C(C), .R(R), .E(E), .s_in(i4.slave), .Q(q4), .BUSY(b4), .UNDERFLOW(u4));
   o_ddr_serializer #(.WIDTH(2), .CHANNELS(1), .IDLE_VALUE(1'b0)) dut2 (
      .C(C), .R(R), .E(E), .s_in(i2.slave), .Q(q2), .BUSY(b2), .UNDERFLOW(u2));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // hi[i]/lo[i] = Q in the high/low phase of the i-th cycle after the load
   typedef struct {
      logic [7:0] d;
      logic [3:0] hi;
      logic [3:0] lo;
   } vec_t;
   vec_t tbl [5];

   // Present one word for one cycle; returns just after the accepting edge.
   task automatic send8(input logic [7:0] d);
      @(posedge C); #2;
      i8.DATA = d; i8.DATA_VALID = 1'b1;
      #1 chk("send_ready", i8.DATA_READY, 1);
      @(posedge C); #2;
      i8.DATA_VALID = 1'b0;
      #1 chk("send_busy_k", b8, 0);
   endtask

   // Check n pairs, then the underflow pulse and idle Q; b2b mode drops valid and checks ready stall.
   task automatic expect8(input string nm, input logic [15:0] hi, input logic [15:0] lo,
                          input int n, input bit b2b);
      for (int i = 0; i < n; i++) begin
         @(posedge C);
         if (b2b && i == 0) begin #2 i8.DATA_VALID = 1'b0; #1; end
         else #3;
         chk($sformatf("%s_hi%0d", nm, i), q8, hi[i]);
         chk($sformatf("%s_busy%0d", nm, i), b8, 1);
         chk($sformatf("%s_uf%0d", nm, i), u8, 0);
         if (b2b && i < 3) chk($sformatf("%s_stall%0d", nm, i), i8.DATA_READY, 0);
         @(negedge C); #1;
         chk($sformatf("%s_lo%0d", nm, i), q8, lo[i]);
      end
      @(posedge C); #3;
      chk({nm, "_uf_pulse"}, u8, 1);
      chk({nm, "_busy_end"}, b8, 0);
      chk({nm, "_q_idle_hi"}, q8, 0);
      @(negedge C); #1;
      chk({nm, "_q_idle_lo"}, q8, 0);
      @(posedge C); #3;
      chk({nm, "_uf_once"}, u8, 0);
   endtask

   // Reference model: queue of waiting words and queue of pairs still to be shown.
   logic [7:0] m_hold [$];
   bit m_hi [$];
   bit m_lo [$];
   bit m_busy, m_p0, m_p1, m_n1, m_uf;

   function automatic bit m_ready(input bit e);
      return e && (m_hold.size() == 0 || !m_busy || m_hi.size() == 0);
   endfunction

   task automatic m_posedge(input bit e, input bit v, input logic [7:0] d);
      bit acc;
      logic [7:0] w;
      m_uf = 1'b0;
      if (e) begin
         acc = v && m_ready(1'b1);
         if (m_hold.size() > 0 && (!m_busy || m_hi.size() == 0)) begin
            w = m_hold.pop_front();
            m_p0 = w[0]; m_p1 = w[1];
            for (int k = 1; k < 4; k++) begin
               m_hi.push_back(w[2*k]);
               m_lo.push_back(w[2*k+1]);
            end
            m_busy = 1'b1;
         end else if (m_busy && m_hi.size() > 0) begin
            m_p0 = m_hi.pop_front();
            m_p1 = m_lo.pop_front();
         end else if (m_busy) begin
            m_busy = 1'b0; m_p0 = 1'b0; m_p1 = 1'b0; m_uf = 1'b1;
         end
         if (acc) m_hold.push_back(d);
      end
   endtask

   logic [1:0] w2 [12];
   logic [15:0] hi16, lo16;

   initial begin
      tbl[0] = '{8'hA5, 4'b0011, 4'b1100};
      tbl[1] = '{8'h3C, 4'b0110, 4'b0110};
      tbl[2] = '{8'hFF, 4'b1111, 4'b1111};
      tbl[3] = '{8'h00, 4'b0000, 4'b0000};
      tbl[4] = '{8'h96, 4'b0110, 4'b1001};

      i8.DATA = 8'hA5; i8.DATA_VALID = 1'b1;
      i4.DATA = '0;    i4.DATA_VALID = 1'b0;
      i2.DATA = '0;    i2.DATA_VALID = 1'b0;
      E = 1'b1;

      // Reset with clock running and valid held
      repeat (3) @(posedge C);
      #3;
      chk("rst_q_hi", q8, 0);
      chk("rst_ready", i8.DATA_READY, 0);
      chk("rst_busy", b8, 0);
      chk("rst_uf", u8, 0);
      @(negedge C); #1;
      chk("rst_q_lo", q8, 0);
      @(posedge C); #2;
      R = 1'b0;
      #1 chk("rel_ready", i8.DATA_READY, 1);
      @(posedge C); #2;
      i8.DATA_VALID = 1'b0;
      expect8("first", {12'h0, tbl[0].hi}, {12'h0, tbl[0].lo}, 4, 1'b0);

      // Single-word vectors
      for (int t = 0; t < 5; t++) begin
         send8(tbl[t].d);
         expect8($sformatf("vec%0d", t), {12'h0, tbl[t].hi}, {12'h0, tbl[t].lo}, 4, 1'b0);
      end

      // Back-to-back A5 then 3C
      @(posedge C); #2;
      i8.DATA = 8'hA5; i8.DATA_VALID = 1'b1;
      @(posedge C); #2;
      i8.DATA = 8'h3C;
      #1 chk("b2b_ready_k", i8.DATA_READY, 1);
      hi16 = {8'h0, tbl[1].hi, tbl[0].hi};
      lo16 = {8'h0, tbl[1].lo, tbl[0].lo};
      expect8("b2b", hi16, lo16, 8, 1'b1);

      // Enable freeze after the second pair
      send8(8'hA5);
      for (int i = 0; i < 2; i++) begin
         @(posedge C); #3 chk($sformatf("frz_pre_hi%0d", i), q8, tbl[0].hi[i]);
         @(negedge C); #1 chk($sformatf("frz_pre_lo%0d", i), q8, tbl[0].lo[i]);
      end
      E = 1'b0; i8.DATA = 8'h3C; i8.DATA_VALID = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge C); #3;
         chk($sformatf("frz_hi%0d", i), q8, tbl[0].hi[1]);
         chk($sformatf("frz_ready%0d", i), i8.DATA_READY, 0);
         chk($sformatf("frz_uf%0d", i), u8, 0);
         chk($sformatf("frz_busy%0d", i), b8, 1);
         @(negedge C); #1;
         chk($sformatf("frz_lo%0d", i), q8, tbl[0].lo[1]);
      end
      E = 1'b1; i8.DATA_VALID = 1'b0;
      expect8("frz_post", {14'h0, tbl[0].hi[3:2]}, {14'h0, tbl[0].lo[3:2]}, 2, 1'b0);

      // Reset in the middle of a word
      send8(8'hA5);
      @(posedge C); #3 chk("mid_hi0", q8, 1);
      @(negedge C); #1 chk("mid_lo0", q8, 0);
      @(posedge C); #3 chk("mid_hi1", q8, 1);
      R = 1'b1;
      #1;
      chk("mid_rst_q_hi", q8, 0);
      chk("mid_rst_busy", b8, 0);
      chk("mid_rst_ready", i8.DATA_READY, 0);
      @(negedge C); #1 chk("mid_rst_q_lo", q8, 0);
      @(posedge C); #2 R = 1'b0;
      send8(8'hFF);
      expect8("after_rst", 16'h000F, 16'h000F, 4, 1'b0);

      // Two lanes, WIDTH=4
      @(posedge C); #2;
      i4.DATA = 8'h96; i4.DATA_VALID = 1'b1;
      @(posedge C); #2 i4.DATA_VALID = 1'b0;
      @(posedge C); #3 chk("ln_c1_hi", q4, 2'b10);
      @(negedge C); #1 chk("ln_c1_lo", q4, 2'b01);
      @(posedge C); #3 chk("ln_c2_hi", q4, 2'b01);
      chk("ln_busy", b4, 1);
      @(negedge C); #1 chk("ln_c2_lo", q4, 2'b10);
      @(posedge C); #3;
      chk("ln_uf", u4, 1);
      chk("ln_idle", q4, 2'b00);

      // WIDTH=2 sustained stream, one word per cycle
      for (int j = 0; j < 12; j++) w2[j] = 2'($urandom_range(0, 3));
      @(posedge C); #2;
      i2.DATA = w2[0]; i2.DATA_VALID = 1'b1;
      for (int j = 0; j < 12; j++) begin
         @(posedge C); #2;
         if (j < 11) i2.DATA = w2[j+1];
         else i2.DATA_VALID = 1'b0;
         #1;
         if (j < 11) chk($sformatf("w2_ready%0d", j), i2.DATA_READY, 1);
         if (j > 0) begin
            chk($sformatf("w2_hi%0d", j), q2, w2[j-1][0]);
            chk($sformatf("w2_uf%0d", j), u2, 0);
         end
         @(negedge C); #1;
         if (j > 0) chk($sformatf("w2_lo%0d", j), q2, w2[j-1][1]);
      end
      @(posedge C); #3 chk("w2_last_hi", q2, w2[11][0]);
      @(negedge C); #1 chk("w2_last_lo", q2, w2[11][1]);
      @(posedge C); #3 chk("w2_uf_end", u2, 1);

      // Randomized run against the model
      @(posedge C); #2 R = 1'b1; E = 1'b1; i8.DATA_VALID = 1'b0;
      @(posedge C); #2 R = 1'b0;
      m_hold.delete(); m_hi.delete(); m_lo.delete();
      m_busy = 0; m_p0 = 0; m_p1 = 0; m_n1 = 0; m_uf = 0;
      for (int n = 0; n < 400; n++) begin
         @(posedge C);
         m_posedge(E, i8.DATA_VALID, i8.DATA);
         #2;
         E = ($urandom_range(0, 9) != 0);
         i8.DATA_VALID = ($urandom_range(0, 2) != 0);
         i8.DATA = 8'($urandom);
         #1;
         chk("rnd_hi", q8, m_p0);
         chk("rnd_busy", b8, m_busy);
         chk("rnd_uf", u8, m_uf && E);
         chk("rnd_ready", i8.DATA_READY, m_ready(E));
         @(negedge C);
         if (E) m_n1 = m_p1;
         #1 chk("rnd_lo", q8, m_n1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1, "time limit");
   end

endmodule
